// File: rtl/i2s_frame_scheduler.sv
// I2S frame timing and sample sequencer: divides clk into BCLK/LRCLK, prefetches one
// stereo pair per frame from the selected source and strobes one slot word per slot.
module i2s_frame_scheduler #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned SLOT_BITS = 16,
  parameter int unsigned NUM_SRC   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [$clog2(NUM_SRC)-1:0]   src_sel,
  input  logic [NUM_SRC-1:0]           src_valid,
  input  logic [NUM_SRC*SLOT_BITS-1:0] src_left,
  input  logic [NUM_SRC*SLOT_BITS-1:0] src_right,
  output logic [NUM_SRC-1:0]           src_ready,
  output logic                         bclk,
  output logic                         lrclk,
  output logic                         word_load,
  output logic [SLOT_BITS-1:0]         word_data,
  output logic                         frame_start,
  output logic [7:0]                   underrun_count
);

  localparam int unsigned SEL_W = $clog2(NUM_SRC);
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(SLOT_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SLOT_BITS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state;
  state_t               next_state;
  logic [DIV_W-1:0]     div_cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic [SEL_W-1:0]     active_sel;
  logic                 pair_valid;
  logic [SLOT_BITS-1:0] pair_l;
  logic [SLOT_BITS-1:0] pair_r;
  logic [SLOT_BITS-1:0] right_hold;

  logic                 div_wrap_c;
  logic                 fall_c;
  logic                 load_left_c;
  logic                 load_right_c;
  logic                 fetch_c;
  logic [SEL_W-1:0]     sel_c;

  logic [SLOT_BITS-1:0] left_arr  [NUM_SRC];
  logic [SLOT_BITS-1:0] right_arr [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign left_arr[i]  = src_left[i*SLOT_BITS +: SLOT_BITS];
    assign right_arr[i] = src_right[i*SLOT_BITS +: SLOT_BITS];
  end

  // Out-of-range selections fall back to source 0
  assign sel_c   = ({1'b0, src_sel} < (SEL_W+1)'(NUM_SRC)) ? src_sel : '0;
  assign fetch_c = ~pair_valid & src_valid[active_sel];

  always_comb begin
    src_ready = '0;
    if (!reset) src_ready[active_sel] = ~pair_valid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Slot boundaries sit on the BCLK fall that ends the last bit of a slot
  always_comb begin
    next_state   = state;
    load_left_c  = 1'b0;
    load_right_c = 1'b0;
    fall_c       = 1'b0;
    div_wrap_c   = (div_cnt == DIV_LAST);
    case (state)
      IDLE: begin
        if (enable) begin
          next_state  = RUN;
          load_left_c = 1'b1;
        end
      end
      RUN: begin
        fall_c = div_wrap_c & bclk;
        if (fall_c && (bit_idx == BIT_LAST)) begin
          if (!lrclk)      load_right_c = 1'b1;
          else if (enable) load_left_c  = 1'b1;
          else             next_state   = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt        <= '0;
      bit_idx        <= '0;
      bclk           <= 1'b0;
      lrclk          <= 1'b0;
      word_load      <= 1'b0;
      frame_start    <= 1'b0;
      word_data      <= '0;
      underrun_count <= '0;
      active_sel     <= '0;
      pair_valid     <= 1'b0;
      pair_l         <= '0;
      pair_r         <= '0;
      right_hold     <= '0;
    end else begin
      word_load   <= load_left_c | load_right_c;
      frame_start <= load_left_c;

      if ((state == RUN) && (next_state == RUN)) begin
        div_cnt <= div_wrap_c ? '0 : div_cnt + DIV_W'(1);
        if (div_wrap_c) bclk <= ~bclk;
        if (fall_c)     bit_idx <= (bit_idx == BIT_LAST) ? '0 : bit_idx + BIT_W'(1);
      end else begin
        div_cnt <= '0;
        bclk    <= 1'b0;
        bit_idx <= '0;
      end

      if (next_state == IDLE) lrclk <= 1'b0;
      if (state == IDLE) active_sel <= sel_c;

      if (fetch_c) begin
        pair_l     <= left_arr[active_sel];
        pair_r     <= right_arr[active_sel];
        pair_valid <= 1'b1;
      end

      // Left load consumes the prefetched pair, or plays silence on underrun
      if (load_left_c) begin
        lrclk      <= 1'b0;
        active_sel <= sel_c;
        if (pair_valid) begin
          word_data  <= pair_l;
          right_hold <= pair_r;
          pair_valid <= 1'b0;
        end else begin
          word_data  <= '0;
          right_hold <= '0;
          if (underrun_count != 8'hFF) underrun_count <= underrun_count + 8'd1;
        end
      end

      if (load_right_c) begin
        lrclk     <= 1'b1;
        word_data <= right_hold;
      end
    end
  end

endmodule

// File: tb/tb_i2s_frame_scheduler.sv
// Scoreboarded bench for i2s_frame_scheduler: default instance plus a CLK_DIV=1/SLOT_BITS=2 instance.
module tb_i2s_frame_scheduler;

  typedef struct {
    logic        lr;
    logic [15:0] data;
    logic        fs;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          rel = 0;
  exp_t        q1[$];
  exp_t        q2[$];
  exp_t        e1, e2;

  // Default instance
  logic        enable;
  logic [1:0]  src_sel;
  logic [3:0]  src_valid;
  logic [63:0] src_left, src_right;
  logic [3:0]  src_ready;
  logic        bclk, lrclk, word_load, frame_start;
  logic [15:0] word_data;
  logic [7:0]  underrun_count;
  logic [15:0] l0, r0;
  logic        v0, v2;
  logic [15:0] n2 = '0;

  assign src_left  = {16'h0, 16'h2000 + n2, 16'h0, l0};
  assign src_right = {16'h0, 16'h2100 + n2, 16'h0, r0};
  assign src_valid = {1'b0, v2, 1'b0, v0};

  i2s_frame_scheduler dut (
    .clk(clk), .reset(reset), .enable(enable), .src_sel(src_sel),
    .src_valid(src_valid), .src_left(src_left), .src_right(src_right),
    .src_ready(src_ready), .bclk(bclk), .lrclk(lrclk), .word_load(word_load),
    .word_data(word_data), .frame_start(frame_start), .underrun_count(underrun_count)
  );

  // Fast instance
  logic        en2;
  logic [0:0]  sel2;
  logic [1:0]  valid2, ready2, wd2;
  logic [3:0]  left2, right2;
  logic        bclk2, lrclk2, wl2, fs2;
  logic [7:0]  ur2;
  logic        bv;
  logic [1:0]  nb = '0;

  assign left2  = {2'b00, nb};
  assign right2 = {2'b00, ~nb};
  assign valid2 = {1'b0, bv};

  i2s_frame_scheduler #(.CLK_DIV(1), .SLOT_BITS(2), .NUM_SRC(2)) dut2 (
    .clk(clk), .reset(reset), .enable(en2), .src_sel(sel2),
    .src_valid(valid2), .src_left(left2), .src_right(right2),
    .src_ready(ready2), .bclk(bclk2), .lrclk(lrclk2), .word_load(wl2),
    .word_data(wd2), .frame_start(fs2), .underrun_count(ur2)
  );

  always #5 clk = ~clk;

  // Incrementing sources advance on each accepted handshake
  always @(posedge clk) begin
    if (src_valid[2] && src_ready[2]) n2 <= n2 + 16'd1;
    if (valid2[0] && ready2[0]) nb <= nb + 2'd1;
  end

  always @(negedge clk) begin
    if (word_load) begin
      n_cmp++;
      if (q1.size() == 0) begin
        n_bad++;
        $display("FAIL load_unexpected: got lr=%0d data=%h fs=%0d, required no load", lrclk, word_data, frame_start);
      end else begin
        e1 = q1.pop_front();
        if ({lrclk, word_data, frame_start} !== {e1.lr, e1.data, e1.fs}) begin
          n_bad++;
          $display("FAIL load: got lr=%0d data=%h fs=%0d, required lr=%0d data=%h fs=%0d",
                   lrclk, word_data, frame_start, e1.lr, e1.data, e1.fs);
        end
      end
    end
    if (wl2) begin
      n_cmp++;
      if (q2.size() == 0) begin
        n_bad++;
        $display("FAIL load2_unexpected: got lr=%0d data=%h fs=%0d, required no load", lrclk2, wd2, fs2);
      end else begin
        e2 = q2.pop_front();
        if ({lrclk2, 16'(wd2), fs2} !== {e2.lr, e2.data, e2.fs}) begin
          n_bad++;
          $display("FAIL load2: got lr=%0d data=%h fs=%0d, required lr=%0d data=%h fs=%0d",
                   lrclk2, wd2, fs2, e2.lr, e2.data, e2.fs);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    rel += n;
    #1;
  endtask

  task automatic step_to(input int k);
    step(k - rel);
  endtask

  task automatic push1(input logic lr, input logic [15:0] d, input logic fs);
    exp_t e;
    e.lr = lr; e.data = d; e.fs = fs;
    q1.push_back(e);
  endtask

  task automatic push2(input logic lr, input logic [15:0] d, input logic fs);
    exp_t e;
    e.lr = lr; e.data = d; e.fs = fs;
    q2.push_back(e);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; src_sel = 2'd0; l0 = '0; r0 = '0; v0 = 1'b0; v2 = 1'b0;
    en2 = 1'b0; sel2 = 1'b0; bv = 1'b0;
    step(2);
    check("rst_bclk", 32'(bclk), 0);
    check("rst_lrclk", 32'(lrclk), 0);
    check("rst_word_load", 32'(word_load), 0);
    check("rst_word_data", 32'(word_data), 0);
    check("rst_frame_start", 32'(frame_start), 0);
    check("rst_underrun", 32'(underrun_count), 0);
    check("rst_src_ready", 32'(src_ready), 0);
    check("rst_src_ready2", 32'(ready2), 0);
    reset = 1'b0; bv = 1'b1;

    // Fast instance: 4-cycle slots, refill before every left load
    step(1);
    push2(0, 16'h0, 1); push2(1, 16'h3, 0); push2(0, 16'h1, 1);
    push2(1, 16'h2, 0); push2(0, 16'h2, 1); push2(1, 16'h1, 0);
    en2 = 1'b1;
    step(1); rel = 0;
    check("fast_bclk_r0", 32'(bclk2), 0);
    step_to(1); check("fast_bclk_r1", 32'(bclk2), 1);
    step_to(2); check("fast_bclk_r2", 32'(bclk2), 0);
    step_to(3); check("fast_no_load_r3", 32'(wl2), 0);
    step_to(21); en2 = 1'b0;
    step_to(24);
    check("fast_idle_load", 32'(wl2), 0);
    check("fast_idle_bclk", 32'(bclk2), 0);
    check("fast_idle_lrclk", 32'(lrclk2), 0);
    bv = 1'b0;

    // Prefilled pair, then three underrun frames
    l0 = 16'h1234; r0 = 16'hABCD; v0 = 1'b1;
    step(1);
    check("prefill_ready_drop", 32'(src_ready), 0);
    v0 = 1'b0;
    push1(0, 16'h1234, 1); push1(1, 16'hABCD, 0);
    for (int i = 0; i < 3; i++) begin push1(0, 16'h0, 1); push1(1, 16'h0, 0); end
    enable = 1'b1;
    step(1); rel = 0;
    check("p1_bclk_r0", 32'(bclk), 0);
    step_to(3); check("p1_bclk_r3", 32'(bclk), 1);
    step_to(5); check("p1_bclk_r5", 32'(bclk), 0);
    step_to(7); check("p1_bclk_r7", 32'(bclk), 1);
    step_to(63);
    check("p1_no_load_r63", 32'(word_load), 0);
    check("p1_lrclk_r63", 32'(lrclk), 0);
    step_to(64); check("p1_lrclk_r64", 32'(lrclk), 1);
    step_to(128); check("p1_underrun_1", 32'(underrun_count), 1);
    step_to(384); check("p1_underrun_3", 32'(underrun_count), 3);
    step_to(460); enable = 1'b0;
    step_to(512);
    check("p1_stop_load", 32'(word_load), 0);
    check("p1_stop_bclk", 32'(bclk), 0);
    check("p1_stop_lrclk", 32'(lrclk), 0);

    // 300 more underruns: counter saturates
    for (int i = 0; i < 300; i++) begin push1(0, 16'h0, 1); push1(1, 16'h0, 0); end
    enable = 1'b1;
    step(1); rel = 0;
    check("sat_first", 32'(underrun_count), 4);
    step_to(128*250); check("sat_254", 32'(underrun_count), 254);
    step_to(128*251); check("sat_255", 32'(underrun_count), 255);
    step_to(128*299 + 70); enable = 1'b0;
    step_to(128*300);
    check("sat_hold", 32'(underrun_count), 255);
    check("sat_stop_load", 32'(word_load), 0);

    // Source switch mid-frame: buffered old pair plays before new source
    l0 = 16'h1111; r0 = 16'h2222; v0 = 1'b1;
    step(1);
    v0 = 1'b0; v2 = 1'b1;
    push1(0, 16'h1111, 1); push1(1, 16'h2222, 0); push1(0, 16'h3333, 1); push1(1, 16'h4444, 0);
    push1(0, 16'h2000, 1); push1(1, 16'h2100, 0); push1(0, 16'h2001, 1); push1(1, 16'h2101, 0);
    enable = 1'b1;
    step(1); rel = 0;
    check("sw_ready_src0", 32'(src_ready), 32'h1);
    l0 = 16'h3333; r0 = 16'h4444; v0 = 1'b1;
    step_to(1);
    check("sw_refill_ready", 32'(src_ready), 0);
    v0 = 1'b0;
    step_to(30); src_sel = 2'd2;
    step_to(31); check("sw_ready_held", 32'(src_ready), 0);
    step_to(128); check("sw_ready_src2", 32'(src_ready), 32'h4);
    step_to(129); check("sw_src2_fetched", 32'(src_ready), 0);

    // Drop enable in a right slot; frame completes, pair is retained
    step_to(460); enable = 1'b0;
    step_to(512);
    check("stop_load", 32'(word_load), 0);
    check("stop_bclk", 32'(bclk), 0);
    check("stop_lrclk", 32'(lrclk), 0);
    check("stop_pair_kept", 32'(src_ready), 0);
    step_to(520);
    push1(0, 16'h2002, 1); push1(1, 16'h2102, 0);
    enable = 1'b1;
    step(1); rel = 0;

    // Asynchronous reset in a right slot with a pair buffered
    step_to(100);
    #2 reset = 1'b1;
    #1;
    check("arst_bclk", 32'(bclk), 0);
    check("arst_lrclk", 32'(lrclk), 0);
    check("arst_word_data", 32'(word_data), 0);
    check("arst_underrun", 32'(underrun_count), 0);
    check("arst_src_ready", 32'(src_ready), 0);
    step(2);
    push1(0, 16'h0, 1); push1(1, 16'h0, 0); push1(0, 16'h2004, 1); push1(1, 16'h2104, 0);
    reset = 1'b0;
    step(1); rel = 0;
    check("arst_first_underrun", 32'(underrun_count), 1);
    step_to(200); enable = 1'b0;
    step_to(256);
    check("end_idle_load", 32'(word_load), 0);
    check("end_q1_drained", 32'(q1.size()), 0);
    check("end_q2_drained", 32'(q2.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2s_frame_scheduler.md
Name: i2s_frame_scheduler

Overview:
- Timing and sample-sequencing controller for the 16-bit I2S serializer path.
- Derives BCLK and LRCLK from the system clock by integer division.
- Selects one of NUM_SRC upstream stereo sample sources, prefetches one L/R pair per frame over a valid/ready handshake, and presents one parallel slot word with a load strobe at each slot boundary.
- On underrun, outputs silence and counts the event.

Parameters:
- CLK_DIV, 2, clk cycles per BCLK half-period (>=1)
- SLOT_BITS, 16, BCLK periods per channel slot (>=2); also the sample width
- NUM_SRC, 4, number of upstream sources (2..8)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  run request
- src_sel  in  $clog2(NUM_SRC)  requested source index
- src_valid  in  NUM_SRC  per-source pair valid
- src_left  in  NUM_SRC*SLOT_BITS  packed left samples; source i occupies [i*SLOT_BITS +: SLOT_BITS]
- src_right  in  NUM_SRC*SLOT_BITS  packed right samples, same packing
- src_ready  out  NUM_SRC  per-source ready, one-hot or zero
- bclk  out  1  bit clock
- lrclk  out  1  0 = left slot, 1 = right slot
- word_load  out  1  1-cycle strobe: word_data valid for the new slot
- word_data  out  SLOT_BITS  slot sample, held between strobes
- frame_start  out  1  word_load qualified with left slot
- underrun_count  out  8  saturating underrun counter

Behaviour:
- Reset values:
  - All outputs 0: bclk, lrclk, word_load, word_data, frame_start, underrun_count, src_ready.
  - Internal: FSM=IDLE, pair_valid=0, active_sel=0, div_cnt=0, bit_idx=0.
- FSM IDLE:
  - bclk=0, lrclk=0, counters held at 0.
  - active_sel <= src_sel every cycle.
  - When enable=1: the same cycle performs a left-slot load, and the FSM enters RUN.
- FSM RUN:
  - div_cnt counts 0..CLK_DIV-1; bclk toggles on div_cnt==CLK_DIV-1.
  - A 1->0 bclk toggle is a "fall event", once per 2*CLK_DIV cycles.
  - bit_idx increments on each fall event.
  - On a fall event with bit_idx==SLOT_BITS-1: bit_idx wraps to 0 and a slot load occurs, alternating right, left, right, ...
  - Each slot is SLOT_BITS BCLK periods; a frame is 4*CLK_DIV*SLOT_BITS clk cycles (128 at defaults).
- Left-slot load:
  - lrclk <= 0 and word_load=1 for one cycle.
  - frame_start=1 for the same cycle.
  - If pair_valid=1: word_data <= pair_l, right_hold <= pair_r, pair_valid <= 0.
  - Else (underrun): word_data <= 0, right_hold <= 0, underrun_count++ saturating at 255.
  - active_sel <= src_sel in the same cycle; this is the only point in RUN where the source changes.
  - If enable=0 here: the FSM goes to IDLE instead and no load occurs (bclk=0, lrclk=0). The current frame is always completed.
- Right-slot load: lrclk <= 1, word_load=1, word_data <= right_hold.
- Fetch handshake:
  - src_ready[active_sel] = ~pair_valid, valid in both IDLE and RUN (allows prefill); all other ready bits are 0.
  - On src_valid[active_sel] & ready: capture the L/R pair and set pair_valid <= 1.
  - A fetch and a left load never coincide: ready=0 while pair_valid=1. After consumption, ready rises the next cycle.
  - The pair consumed in frame F was fetched during frame F-1 from the source active at the start of F-1.
  - After a src_sel change, the first pair from the new source plays one frame later. The already-buffered pair from the old source is not flushed.
- Reset mid-operation: all state returns to reset values immediately and asynchronously. A partially transmitted frame is abandoned.
- src_sel >= NUM_SRC: treated as 0.
- word_data changes only on word_load cycles.
- lrclk changes only on load cycles, coincident with a bclk fall.

Test Plan:
- Defaults; prefill source 0 with L=0x1234, R=0xABCD; raise enable at cycle T -> left load at T (word_data=0x1234, frame_start=1). Right load at T+64 (0xABCD, lrclk=1). Next left load at T+128. bclk period is 4 cycles.
- No source valid; enable for 3 frames -> three left loads with word_data=0, right words 0, underrun_count=3. Force 300 underruns -> count holds at 255.
- Source 2 always valid with incrementing data; switch src_sel from 0 to 2 mid-frame -> src_ready moves to bit 2 only after the next left load. The old buffered pair plays first, then source 2 data.
- Drop enable mid-frame at a right slot -> the right slot completes. At the next frame boundary: bclk=0, lrclk=0, no word_load; the buffered pair is retained and plays when re-enabled.
- Assert reset during the right slot with pair_valid=1 -> all outputs 0 asynchronously and pair_valid cleared. After release with enable=1, the first load is a left underrun.
- CLK_DIV=1, SLOT_BITS=2 -> bclk toggles every cycle; loads every 4 cycles alternating left/right; the handshake still refills before each left load.
